mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). It arbitrates, sequences a valid/ready command plus read-response handshake to the memory, and returns per-requester acks and read data. It also produces the stall signals that freeze the PC and pipeline buffers while an access is pending. It sits between the pipeline and a unified memory model that replaces the separate instruction and data memories.

Parameters:
STARVE_LIMIT, 3, max consecutive data grants issued while IF is waiting before IF is forced a grant (1..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
if_req_i  in  1  fetch request; held with address until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_ack_o  out  1  one-cycle pulse, fetch complete
if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1, held afterwards
dm_req_i  in  1  data request; held with operands until dm_ack_o
dm_we_i  in  1  1=store, 0=load
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_ack_o  out  1  one-cycle pulse, data access complete
dm_rdata_o  out  DATA_W  load data, valid while dm_ack_o=1, held afterwards
cmd_valid_o  out  1  command to memory valid
cmd_ready_i  in  1  memory accepts command
cmd_we_o  out  1  command is a write
cmd_addr_o  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
cmd_wdata_o  out  DATA_W  write data
rsp_valid_i  in  1  read data valid (reads only)
rsp_data_i  in  DATA_W  read data
stall_if_o  out  1  if_req_i & ~if_ack_o (combinational)
stall_dm_o  out  1  dm_req_i & ~dm_ack_o (combinational)

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RSP, ACK. Reset: IDLE; all registered outputs 0; rdata regs 0; starve_cnt 0; owner=DM.
- IDLE: if any request, grant, latch owner/we/addr/wdata, go ISSUE. No request: stay.
- Grant rule: only dm_req -> DM; only if_req -> IF; both -> DM unless starve_cnt==STARVE_LIMIT, then IF.
- starve_cnt: +1 on a DM grant while if_req_i=1 (saturating at STARVE_LIMIT); cleared on an IF grant, or on a DM grant while if_req_i=0.
- ISSUE: cmd_valid_o=1 with latched fields stable until a cycle with cmd_ready_i=1 (accept). On accept: write -> ACK; read -> WAIT_RSP. cmd_valid_o never drops before accept.
- WAIT_RSP: cmd_valid_o=0; on rsp_valid_i capture rsp_data_i into the owner's rdata reg, go ACK.
- ACK: owner's ack pulses exactly one cycle; no arbitration this cycle (prevents regrant of a still-high req); next IDLE.
- Minimum latency req->ack: write 3 cycles (cmd_ready_i high on first ISSUE cycle); read 4 cycles with rsp_valid_i next cycle.
- Back-to-back: a new grant is possible in the IDLE cycle right after ACK; throughput one access per 3 (write) / 4 (read) cycles.
- rsp_valid_i outside WAIT_RSP: ignored, no state change.
- Requester deasserting req before grant: no effect. After grant, the transaction completes and acks even if req drops.
- Non-owner rdata reg holds its value across other transactions.
- rst_i mid-transaction: immediate (asynchronous) return to IDLE, cmd_valid_o=0, acks 0, counter 0. In-flight memory response is dropped.
- IF never issues writes; cmd_we_o=0 for IF grants.

Test Plan:
- Reset: rst_i=1 during ISSUE with cmd_valid_o=1 -> cmd_valid_o=0 same cycle, state IDLE, rdata regs 0, starve_cnt 0.
- Single fetch: if_req_i=1, addr 0x0000_0013, cmd_ready_i=1, rsp_valid_i one cycle later with data 0x0000_0093 -> cmd_addr_o=0x10, if_ack_o pulse 4 cycles after req, if_rdata_o=0x93.
- Store with backpressure: dm_we_i=1, addr 0x40, wdata 0xDEADBEEF, cmd_ready_i low 5 cycles -> cmd fields stable for 6 cycles, dm_ack_o one cycle after accept, stall_dm_o=1 until ack.
- Contention: both req simultaneously -> DM granted first, IF waits, stall_if_o=1.
- Starvation: STARVE_LIMIT=3, dm_req_i and if_req_i held high continuously -> grants DM,DM,DM,IF,DM..., counter clears after the IF grant.
- Spurious rsp_valid_i in IDLE/ISSUE with data 0xFFFF_FFFF -> no ack, rdata unchanged; no regrant in the ACK cycle despite req still high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch (IF) and load/store (DM).
// Runs a valid/ready command with a read-response handshake, and returns acks, read data and stalls.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic              cmd_we_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [DATA_W-1:0] cmd_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              stall_if_o,
    output logic              stall_dm_o
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] ACK      = 2'd3;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    logic              owner_if_q, owner_if_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [3:0]        starve_q, starve_d;
    logic              grant_if;

    // DM wins ties unless IF has already been passed over STARVE_LIMIT times in a row.
    assign grant_if = if_req_i & (~dm_req_i | (starve_q == LIMIT));

    always_comb begin
        state_d    = state_q;
        owner_if_d = owner_if_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_d   = starve_q;
        unique case (state_q)
            IDLE: begin
                if (if_req_i | dm_req_i) begin
                    state_d    = ISSUE;
                    owner_if_d = grant_if;
                    if (grant_if) begin
                        we_d     = 1'b0;
                        addr_d   = if_addr_i;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        we_d    = dm_we_i;
                        addr_d  = dm_addr_i;
                        wdata_d = dm_wdata_i;
                        if (!if_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != LIMIT) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready_i) begin
                    state_d = we_q ? ACK : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid_i) begin
                    state_d = ACK;
                    if (owner_if_q) begin
                        if_rdata_d = rsp_data_i;
                    end else begin
                        dm_rdata_d = rsp_data_i;
                    end
                end
            end
            ACK: begin
                // No arbitration here, so a request still held high is not granted twice.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_if_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            starve_q   <= starve_d;
        end
    end

    assign cmd_valid_o = (state_q == ISSUE);
    assign cmd_we_o    = we_q;
    assign cmd_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign cmd_wdata_o = wdata_q;
    assign if_ack_o    = (state_q == ACK) & owner_if_q;
    assign dm_ack_o    = (state_q == ACK) & ~owner_if_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_if_o  = if_req_i & ~if_ack_o;
    assign stall_dm_o  = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for backpressure, spurious responses, starvation and reset.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b0;
    logic        cmd_we_o;
    logic [31:0] cmd_addr_o;
    logic [31:0] cmd_wdata_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        stall_if_o;
    logic        stall_dm_o;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.STARVE_LIMIT(3), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_we_o(cmd_we_o),
        .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .stall_if_o(stall_if_o), .stall_dm_o(stall_dm_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_if;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cmd(output logic ok);
        int n = 0;
        while (!cmd_valid_o && n < 8) begin
            tick();
            n++;
        end
        ok = cmd_valid_o;
    endtask

    initial begin
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
        logic        exp_we;
        logic        ok;
        logic        got_if;
        logic [6:0]  exp_own;
        vec_t        v;

        // {is_if, we (dm_we_i driven), addr, wdata, rsp, expected cmd_addr}
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0093, 32'h0000_0010};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0047, 32'h0,         32'hCAFE_F00D, 32'h0000_0044};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         32'h0000_0040};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'h1111_2222, 32'hFFFF_FFFC};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'h5A5A_A5A5, 32'h0000_1000};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 32'h0,         32'h0000_0000};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, 32'h0000_0008};
        exp_if = '0;
        exp_dm = '0;

        tick();
        tick();
        check("rst_cmd_valid", {31'b0, cmd_valid_o}, 32'd0);
        check("rst_acks", {30'b0, if_ack_o, dm_ack_o}, 32'd0);
        check("rst_if_rdata", if_rdata_o, 32'd0);
        check("rst_dm_rdata", dm_rdata_o, 32'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            exp_we = v.is_if ? 1'b0 : v.we;
            dm_we_i = v.we;
            if (v.is_if) begin
                if_req_i  = 1'b1;
                if_addr_i = v.addr;
            end else begin
                dm_req_i   = 1'b1;
                dm_addr_i  = v.addr;
                dm_wdata_i = v.wdata;
            end
            cmd_ready_i = 1'b1;
            tick();
            check($sformatf("vec%0d_cmd_valid", i), {31'b0, cmd_valid_o}, 32'd1);
            check($sformatf("vec%0d_cmd_addr", i), cmd_addr_o, v.exp_addr);
            check($sformatf("vec%0d_cmd_we", i), {31'b0, cmd_we_o}, {31'b0, exp_we});
            if (exp_we) check($sformatf("vec%0d_cmd_wdata", i), cmd_wdata_o, v.wdata);
            check($sformatf("vec%0d_stall", i), {31'b0, v.is_if ? stall_if_o : stall_dm_o}, 32'd1);
            tick();
            if (!exp_we) begin
                check($sformatf("vec%0d_wait_valid", i), {31'b0, cmd_valid_o}, 32'd0);
                check($sformatf("vec%0d_wait_ack", i), {30'b0, if_ack_o, dm_ack_o}, 32'd0);
                rsp_valid_i = 1'b1;
                rsp_data_i  = v.rsp;
                tick();
                rsp_valid_i = 1'b0;
                if (v.is_if) exp_if = v.rsp;
                else exp_dm = v.rsp;
            end
            check($sformatf("vec%0d_acks", i), {30'b0, if_ack_o, dm_ack_o},
                  {30'b0, v.is_if, ~v.is_if});
            check($sformatf("vec%0d_if_rdata", i), if_rdata_o, exp_if);
            check($sformatf("vec%0d_dm_rdata", i), dm_rdata_o, exp_dm);
            if_req_i = 1'b0;
            dm_req_i = 1'b0;
            dm_we_i  = 1'b0;
            tick();
            check($sformatf("vec%0d_ack_done", i), {30'b0, if_ack_o, dm_ack_o}, 32'd0);
        end

        // Store held off by five cycles of backpressure.
        dm_req_i    = 1'b1;
        dm_we_i     = 1'b1;
        dm_addr_i   = 32'h0000_0040;
        dm_wdata_i  = 32'hDEAD_BEEF;
        cmd_ready_i = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c == 5) cmd_ready_i = 1'b1;
            check($sformatf("bp%0d_valid", c), {31'b0, cmd_valid_o}, 32'd1);
            check($sformatf("bp%0d_addr", c), cmd_addr_o, 32'h0000_0040);
            check($sformatf("bp%0d_wdata", c), cmd_wdata_o, 32'hDEAD_BEEF);
            check($sformatf("bp%0d_stall_dm", c), {31'b0, stall_dm_o}, 32'd1);
            tick();
        end
        cmd_ready_i = 1'b0;
        check("bp_dm_ack", {31'b0, dm_ack_o}, 32'd1);
        check("bp_stall_dm_at_ack", {31'b0, stall_dm_o}, 32'd0);
        tick();
        check("bp_no_regrant", {31'b0, cmd_valid_o}, 32'd0);
        check("bp_ack_one_cycle", {31'b0, dm_ack_o}, 32'd0);
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
        tick();

        // Spurious responses in IDLE and ISSUE must be ignored.
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'hFFFF_FFFF;
        tick();
        check("spur_idle_acks", {30'b0, if_ack_o, dm_ack_o}, 32'd0);
        check("spur_idle_dm_rdata", dm_rdata_o, exp_dm);
        dm_req_i  = 1'b1;
        dm_addr_i = 32'h0000_0020;
        tick();
        tick();
        check("spur_issue_valid", {31'b0, cmd_valid_o}, 32'd1);
        check("spur_issue_ack", {31'b0, dm_ack_o}, 32'd0);
        check("spur_issue_dm_rdata", dm_rdata_o, exp_dm);
        rsp_valid_i = 1'b0;
        cmd_ready_i = 1'b1;
        tick();
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'h1234_5678;
        tick();
        rsp_valid_i = 1'b0;
        check("spur_load_ack", {31'b0, dm_ack_o}, 32'd1);
        check("spur_load_rdata", dm_rdata_o, 32'h1234_5678);
        check("spur_if_rdata_held", if_rdata_o, exp_if);
        tick();
        check("spur_no_regrant", {31'b0, cmd_valid_o}, 32'd0);
        dm_req_i = 1'b0;
        tick();

        // Both requesters held: expect DM,DM,DM,IF,DM,DM,DM (bit g set = IF grant).
        exp_own    = 7'b0001000;
        if_addr_i  = 32'h0000_0100;
        dm_addr_i  = 32'h0000_0200;
        dm_we_i    = 1'b1;
        dm_wdata_i = 32'h0000_0077;
        if_req_i   = 1'b1;
        dm_req_i   = 1'b1;
        for (int g = 0; g < 7; g++) begin
            wait_cmd(ok);
            check($sformatf("starve%0d_cmd_seen", g), {31'b0, ok}, 32'd1);
            got_if = (cmd_addr_o == 32'h0000_0100);
            check($sformatf("starve%0d_owner_if", g), {31'b0, got_if}, {31'b0, exp_own[g]});
            if (g == 0) check("contention_stall_if", {31'b0, stall_if_o}, 32'd1);
            if (g == 6) break;
            if (got_if) begin
                tick();
                rsp_valid_i = 1'b1;
                rsp_data_i  = 32'hABCD_0123;
                tick();
                rsp_valid_i = 1'b0;
            end else begin
                tick();
            end
            tick();
        end

        // Reset in ISSUE with the starvation counter at its limit.
        rst_i = 1'b1;
        #1;
        check("midrst_cmd_valid", {31'b0, cmd_valid_o}, 32'd0);
        check("midrst_acks", {30'b0, if_ack_o, dm_ack_o}, 32'd0);
        check("midrst_if_rdata", if_rdata_o, 32'd0);
        check("midrst_dm_rdata", dm_rdata_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check("postrst_cmd_valid", {31'b0, cmd_valid_o}, 32'd1);
        check("postrst_dm_first", cmd_addr_o, 32'h0000_0200);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        rst_i    = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
